aes_encrypt_iter: RTL and testbench
===================================

// Module: aes_encrypt_iter
// PURPOSE
//  Iterative AES encryption core; the forward-direction counterpart of the decrypt datapath.
//  Accepts one 128-bit plaintext block per valid/ready transaction.
//  Uses a pre-expanded key schedule of up to 15 round keys and runs one full round per clock.
//  Returns the ciphertext through a valid/ready output port that supports back-pressure.
//  Supports 128-, 192- and 256-bit keys, selected by switch.
// PARAMETERS
//  NB   4     words per state (fixed by FIPS-197; kept for readability only)
//  KW   1920  key-schedule bus width = 15 round keys x 128 bits
// PORTS
//  clk        in   1     system clock; all state updates on the rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_data    in   128   plaintext; byte 0 in [127:120]
//  in_valid   in   1     in_data, key_e and switch are valid
//  in_ready   out  1     core idle; a transfer occurs when in_valid & in_ready
//  key_e      in   1920  expanded key; round key i at key_e[1919-128*i -:128]
//  switch     in   2     key size: 00 = AES-128 (nr=10), 01 = AES-192 (nr=12), 1x = AES-256 (nr=14)
//  out_data   out  128   ciphertext; byte 0 in [127:120]
//  out_valid  out  1     out_data valid; held until out_ready
//  out_ready  in   1     sink accepts out_data
//  busy       out  1     high in the ROUND state
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, state_reg=0, rcnt=0, nr_reg=10.
//   - Outputs: in_ready=0 while rst_n=0, out_valid=0, busy=0, out_data=0.
//   - An in-flight block is discarded with no output.
//  FSM states: IDLE, ROUND, DONE.
//   IDLE : in_ready=1.
//          On in_valid: state_reg <= in_data ^ rk0; nr_reg <= nr(switch); rcnt <= 1; go to ROUND.
//   ROUND: each cycle state_reg <= round(state_reg, rk[rcnt]); rcnt <= rcnt+1.
//          round = SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//          MixColumns is bypassed when rcnt == nr_reg.
//          When rcnt == nr_reg, go to DONE.
//   DONE : out_valid=1; out_data=state_reg, held stable.
//          On out_ready, go to IDLE (in_ready asserts the following cycle).
//  Latency: out_valid rises exactly nr_reg clocks after the accepting edge.
//   - AES-128: 10, AES-192: 12, AES-256: 14.
//   - Throughput: one block per nr+2 cycles with out_ready held high.
//  in_ready is a function of state only; there is no combinational path from out_ready to in_ready.
//  switch is sampled only at accept. A change to switch mid-block does not affect the current block.
//  key_e is not registered. The source must hold it stable from accept until out_valid.
//  rcnt is 4 bits. Round-key index = rcnt (1..14); it never wraps.
//  switch=2'b11 behaves as 2'b10 (AES-256).
//  in_valid while not in IDLE is ignored; no transfer occurs.
//  out_data is driven directly from state_reg. It is don't-care outside DONE but must not be X after reset.
// STRUCTURE
//  Shared package aes_pkg:
//   - SBOX[256] constant
//   - xtime() function
//   - localparams NR128=10, NR192=12, NR256=14
//   - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
//   - round-key slice helper
//  Sub-module aes_enc_round (combinational):
//   - ports: state_in[127:0], rk[127:0], last (1 = bypass MixColumns), state_out[127:0]
//   - instantiated once; contains 16 S-box lookups, ShiftRows, MixColumns and the XOR
//  Top level: FSM, rcnt, nr_reg, state_reg, round-key mux, handshake logic.
// TESTING
//  T1 AES-128 (FIPS-197 C.1):
//   - pt 00112233445566778899aabbccddeeff, key 000102..0f
//   - expect out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 clocks after accept
//  T2 AES-192 (C.2), same pt, key 00..17:
//   - expect dda97ca4864cdfe06eaf70a0ec0d7191 after 12 clocks
//  T3 AES-256 (C.3), same pt, key 00..1f:
//   - expect 8ea2b7ca516745bfeafc49904b496089 after 14 clocks
//   - repeat with switch=11: same result
//  T4 Back-pressure:
//   - pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//   - hold out_ready=0 for 20 clocks
//   - expect 3925841d02dc09fbdc118597196a0b32 held stable with in_ready=0
//   - pulse in_valid during the hold: ignored
//  T5 Reset mid-block:
//   - assert rst_n=0 at round 5 of T1
//   - expect out_valid=0, out_data=0, busy=0 immediately (asynchronous)
//   - after release, T1 rerun gives the correct result
//  T6 Back-to-back, out_ready tied high:
//   - T1, T2 and T3 blocks issued with in_valid held high
//   - expect 3 correct outputs, each out_valid 1 cycle wide, next accept 1 cycle after each handshake

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, round counts,
// FSM encoding and the round-key selection helper.
package aes_pkg;

    localparam int KEY_W = 1920;

    localparam logic [3:0] NR128 = 4'd10;
    localparam logic [3:0] NR192 = 4'd12;
    localparam logic [3:0] NR256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Number of rounds for a key-size selector; 2'b11 is treated as AES-256.
    function automatic logic [3:0] nr_of(input logic [1:0] sw);
        logic [3:0] nr;
        case (sw)
            2'b00:   nr = NR128;
            2'b01:   nr = NR192;
            default: nr = NR256;
        endcase
        return nr;
    endfunction

    // Round key idx from the flattened schedule (key 0 in the top 128 bits).
    function automatic logic [127:0] rk_slice(input logic [KEY_W-1:0] key, input logic [3:0] idx);
        logic [127:0] rk;
        rk = 128'h0;
        for (int i = 0; i < 15; i++) begin
            if (idx == 4'(i)) begin
                rk = key[KEY_W-1-128*i -: 128];
            end else begin
                rk = rk;
            end
        end
        return rk;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey.
// Byte 0 of the state lives in [127:120]; bytes are column-major.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] sb_s;
    logic [127:0] sr_s;
    logic [127:0] mc_s;
    logic [127:0] pre_key_s;

    // SubBytes: one S-box lookup per byte.
    always_comb begin
        sb_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sb_s[127-8*i -: 8] = SBOX[state_in[127-8*i -: 8]];
        end
    end

    // ShiftRows: row r rotates left by r columns.
    always_comb begin
        sr_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    // MixColumns: fixed polynomial {03}x^3+{01}x^2+{01}x+{02} per column.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mc_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr_s[127-8*(4*c+0) -: 8];
            a1 = sr_s[127-8*(4*c+1) -: 8];
            a2 = sr_s[127-8*(4*c+2) -: 8];
            a3 = sr_s[127-8*(4*c+3) -: 8];
            mc_s[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc_s[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc_s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc_s[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // Final round omits MixColumns, then the round key is added.
    always_comb begin
        if (last) begin
            pre_key_s = sr_s;
        end else begin
            pre_key_s = mc_s;
        end
        state_out = pre_key_s ^ rk;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock, valid/ready on both
// sides, 128/192/256-bit keys from a pre-expanded schedule.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NB = 4,
    parameter int KW = KEY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KW-1:0]     key_e,
    input  logic [1:0]        switch,
    output logic [32*NB-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    aes_state_e   state_r;
    aes_state_e   state_nxt_s;
    logic [3:0]   rcnt_r;
    logic [3:0]   nr_r;
    logic [127:0] data_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;

    logic         accept_s;
    logic         last_s;
    logic [127:0] rk_s;
    logic [127:0] round_s;

    assign accept_s = in_valid & in_ready_r;
    assign last_s   = (rcnt_r == nr_r);
    assign rk_s     = rk_slice(key_e, rcnt_r);

    aes_enc_round u_round (
        .state_in  (data_r),
        .rk        (rk_s),
        .last      (last_s),
        .state_out (round_s)
    );

    // Next-state logic for the IDLE -> ROUND -> DONE block sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ROUND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUND: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ROUND;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus handshake/status flags decoded from the next state,
    // so in_ready stays low through reset and never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s == ROUND);
        end
    end

    // Datapath: initial key whitening on accept, one round per ROUND cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 128'h0;
            rcnt_r <= 4'd0;
            nr_r   <= NR128;
        end else if ((state_r == IDLE) && accept_s) begin
            data_r <= in_data ^ rk_slice(key_e, 4'd0);
            rcnt_r <= 4'd1;
            nr_r   <= nr_of(switch);
        end else if (state_r == ROUND) begin
            data_r <= round_s;
            if (last_s) begin
                rcnt_r <= rcnt_r;
            end else begin
                rcnt_r <= rcnt_r + 4'd1;
            end
        end else begin
            data_r <= data_r;
            rcnt_r <= rcnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = data_r;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, random blocks
// against a byte-level AES model, back-pressure, async reset and back-to-back.
module tb_aes_encrypt_iter;

    typedef logic [7:0] byte_t;

    typedef struct {
        logic [127:0] pt;
        logic [255:0] key;
        logic [1:0]   sw;
        logic [127:0] exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [127:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [1919:0]  key_e;
    logic [1:0]     switch;
    logic [127:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int errors = 0;
    int checks = 0;

    byte_t sbox_m [256];
    vec_t  vecs [12];

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_e     (key_e),
        .switch    (switch),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        byte_t y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (byte_t'({x[6:0], 1'b0}) ^ 8'h1b) : byte_t'({x[6:0], 1'b0});
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic byte_t rotl8(input byte_t v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            byte_t inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(byte_t'(x), byte_t'(y)) == 8'h01) inv = byte_t'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic int nk_of(input logic [1:0] sw);
        if (sw == 2'b00) return 4;
        else if (sw == 2'b01) return 6;
        else return 8;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] ks;
        byte_t         rcon;
        int            total;
        total = 4 * (nk + 7);
        rcon  = 8'h01;
        ks    = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            ks[1919-32*i -: 32] = w[i];
        end
        return ks;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
        byte_t s [16];
        byte_t t [16];
        int    cm [4];
        logic [127:0] res;
        cm = '{2, 3, 1, 1};
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1919-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++) begin
                        byte_t acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(byte_t'(cm[(j-i+4)%4]), s[4*c+j]);
                        t[4*c+i] = acc;
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1919-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    // Wait for in_ready, present a block, and return at the negedge after acceptance.
    task automatic start_block(input vec_t v, input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 128'(in_ready), 128'd1);
        in_data  = v.pt;
        key_e    = expand(v.key, nk_of(v.sw));
        switch   = v.sw;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        switch   = 2'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        check({tag, "_busy"}, 128'(busy), 128'd1);
    endtask

    // Count cycles from acceptance to out_valid and check latency and data.
    task automatic wait_out(input vec_t v, input string tag);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(nk_of(v.sw) + 6));
        check({tag, "_data"}, out_data, v.exp);
    endtask

    task automatic run_block(input vec_t v, input string tag);
        start_block(v, tag);
        wait_out(v, tag);
        @(negedge clk);
        check({tag, "_consumed"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [255:0] kseq;
        build_sbox();
        for (int i = 0; i < 32; i++) kseq[255-8*i -: 8] = byte_t'(i);

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, kseq, 2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, kseq, 2'b01, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, kseq, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{128'h00112233445566778899aabbccddeeff, kseq, 2'b11, 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[4] = '{128'h3243f6a8885a308d313198a2e0370734,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00,
                    128'h3925841d02dc09fbdc118597196a0b32};
        for (int i = 5; i < 12; i++) begin
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vecs[i].sw  = 2'($urandom_range(0, 3));
            vecs[i].exp = model_enc(vecs[i].pt, expand(vecs[i].key, nk_of(vecs[i].sw)), nk_of(vecs[i].sw) + 6);
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = 128'h0; key_e = '0; switch = 2'b00;

        // Reset state
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1-T3 and random blocks, out_ready high
        for (int i = 0; i < 12; i++) begin
            run_block(vecs[i], $sformatf("vec%0d", i));
        end

        // T4 back-pressure with an ignored in_valid pulse
        out_ready = 1'b0;
        start_block(vecs[4], "t4");
        wait_out(vecs[4], "t4");
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t4_hold_data%0d", k), out_data, vecs[4].exp);
            check($sformatf("t4_hold_valid%0d", k), 128'(out_valid), 128'd1);
            check($sformatf("t4_hold_ready%0d", k), 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_valid", 128'(out_valid), 128'd0);
        check("t4_release_ready", 128'(in_ready), 128'd1);
        repeat (3) @(negedge clk);
        check("t4_no_extra_block", 128'(busy | out_valid), 128'd0);

        // T5 asynchronous reset mid-block
        start_block(vecs[0], "t5");
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 128'(out_valid), 128'd0);
        check("t5_rst_out_data", out_data, 128'h0);
        check("t5_rst_busy", 128'(busy), 128'd0);
        check("t5_rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_stale_output", 128'(out_valid), 128'd0);
        run_block(vecs[0], "t5_rerun");

        // T6 back-to-back with in_valid held high
        @(negedge clk);
        in_data  = vecs[0].pt;
        key_e    = expand(vecs[0].key, nk_of(vecs[0].sw));
        switch   = vecs[0].sw;
        in_valid = 1'b1;
        check("t6_ready", 128'(in_ready), 128'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t6_accept%0d", k), 128'(busy), 128'd1);
            wait_out(vecs[k], $sformatf("t6_blk%0d", k));
            if (k < 2) begin
                in_data = vecs[k+1].pt;
                key_e   = expand(vecs[k+1].key, nk_of(vecs[k+1].sw));
                switch  = vecs[k+1].sw;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t6_pulse%0d", k), 128'(out_valid), 128'd0);
            check($sformatf("t6_ready%0d", k), 128'(in_ready), 128'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
